// File: rtl/dc_ipu_shr_pipeline_ctrl.sv
// Elastic pipeline controller: turns an upstream valid/ready handshake into per-stage
// load enables and valid flags, with bubble collapsing, synchronous flush and a stall counter.
module dc_ipu_shr_pipeline_ctrl #(
    parameter int STAGES = 4,
    parameter int CNT_W  = 16,
    localparam int OCC_W = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [STAGES-1:0] stage_en,
    output logic [STAGES-1:0] stage_valid,
    output logic [OCC_W-1:0]  occupancy,
    output logic              empty,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_cnt_clr
);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] v_next;
    logic [STAGES-1:0] rdy;
    logic              chain;
    logic              accept;
    logic              retire;

    // A stage can load when it is empty or the stage after it is moving; the
    // running 'chain' avoids reading back bits of the vector being built.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        rdy   = '0;
        chain = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            chain  = !v[i] | chain;
            rdy[i] = chain;
        end
    end

    assign stage_en  = flush ? '0 : rdy;
    assign in_ready  = !flush & rdy[0];
    assign out_valid = !flush & v[STAGES-1];
    assign accept    = in_valid & in_ready;
    assign retire    = out_valid & out_ready;

    always_comb begin
        v_next = v;
        if (flush) begin
            v_next = '0;
        end else begin
            if (rdy[0]) v_next[0] = in_valid;
            for (int i = 1; i < STAGES; i++) begin
                if (rdy[i]) v_next[i] = v[i-1];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            v         <= '0;
            occupancy <= '0;
            stall_cnt <= '0;
        end else begin
            v <= v_next;

            if (flush)
                occupancy <= '0;
            else if (accept && !retire)
                occupancy <= occupancy + OCC_W'(1);
            else if (retire && !accept)
                occupancy <= occupancy - OCC_W'(1);

            // Clear wins over increment; the count sticks at all-ones.
            if (stall_cnt_clr)
                stall_cnt <= '0;
            else if (out_valid && !out_ready && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign stage_valid = v;
    assign empty       = (occupancy == '0);

endmodule

// File: tb/tb_dc_ipu_shr_pipeline_ctrl.sv
// Self-checking bench for dc_ipu_shr_pipeline_ctrl: directed scenarios plus random traffic
// compared against a slot-occupancy reference model.
module tb_dc_ipu_shr_pipeline_ctrl;

    localparam int STAGES = 4;
    localparam int CNT_W  = 4;
    localparam int OCC_W  = $clog2(STAGES + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              nreset = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [STAGES-1:0] stage_en;
    logic [STAGES-1:0] stage_valid;
    logic [OCC_W-1:0]  occupancy;
    logic              empty;
    logic [CNT_W-1:0]  stall_cnt;
    logic              stall_cnt_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    // Reference model: which slots hold an item, and the stall count.
    bit m_slot [STAGES];
    int m_cnt;

    // Values sampled at the most recent step, for directed checks.
    logic s_ov, s_ir;
    logic [STAGES-1:0] s_en;

    dc_ipu_shr_pipeline_ctrl #(.STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk(clk), .nreset(nreset), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
        .stage_en(stage_en), .stage_valid(stage_valid), .occupancy(occupancy),
        .empty(empty), .stall_cnt(stall_cnt), .stall_cnt_clr(stall_cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < STAGES; i++) n += int'(m_slot[i]);
        return n;
    endfunction

    function automatic logic [STAGES-1:0] model_valid();
        logic [STAGES-1:0] r = '0;
        for (int i = 0; i < STAGES; i++) r[i] = m_slot[i];
        return r;
    endfunction

    // Stage i moves iff the output drains or a hole exists at or after i.
    function automatic logic [STAGES-1:0] model_en(input logic f, input logic ordy);
        logic [STAGES-1:0] r = '0;
        if (!f) begin
            for (int i = 0; i < STAGES; i++) begin
                bit hole = 0;
                for (int j = i; j < STAGES; j++) if (!m_slot[j]) hole = 1;
                r[i] = ordy | hole;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < STAGES; i++) m_slot[i] = 0;
        m_cnt = 0;
    endtask

    // One clock: drive inputs, compare all outputs against the model, then advance both.
    task automatic step(input logic f, input logic iv, input logic ordy, input logic clr);
        logic [STAGES-1:0] en;
        logic exp_ov, exp_ir;
        bit old [STAGES];
        @(negedge clk);
        flush = f; in_valid = iv; out_ready = ordy; stall_cnt_clr = clr;
        #1;
        en     = model_en(f, ordy);
        exp_ir = en[0];
        exp_ov = !f && m_slot[STAGES-1];
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("stage_en", 32'(stage_en), 32'(en));
        chk("stage_valid", 32'(stage_valid), 32'(model_valid()));
        chk("occupancy", 32'(occupancy), 32'(model_count()));
        chk("empty", 32'(empty), 32'(model_count() == 0));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        s_ov = out_valid; s_ir = in_ready; s_en = stage_en;
        @(posedge clk);
        if (clr) m_cnt = 0;
        else if (exp_ov && !ordy && m_cnt < CNT_MAX) m_cnt++;
        old = m_slot;
        if (f) begin
            for (int i = 0; i < STAGES; i++) m_slot[i] = 0;
        end else begin
            for (int i = 0; i < STAGES; i++)
                if (en[i]) m_slot[i] = (i == 0) ? bit'(iv) : old[i-1];
        end
    endtask

    initial begin
        int first_ov;
        int n_out;
        model_reset();

        // Reset state
        #12 nreset = 1'b1;
        @(negedge clk); #1;
        chk("rst_stage_valid", 32'(stage_valid), 32'h0);
        chk("rst_occupancy", 32'(occupancy), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_stage_en", 32'(stage_en), 32'hF);

        // Streaming: first output after STAGES cycles, occupancy settles full
        first_ov = -1;
        for (int c = 0; c < 10; c++) begin
            step(0, 1, 1, 0);
            if (s_ov && first_ov < 0) first_ov = c;
        end
        chk("stream_first_ov", 32'(first_ov), 32'd4);
        step(0, 1, 1, 0);
        chk("stream_occ_full", 32'(occupancy), 32'd4);
        chk("stream_no_stall", 32'(stall_cnt), 32'd0);

        // Back-pressure on a full pipeline
        for (int c = 0; c < 5; c++) step(0, 1, 0, 0);
        chk("bp_in_ready", 32'(s_ir), 32'd0);
        chk("bp_stage_en", 32'(s_en), 32'h0);
        step(0, 0, 1, 0);
        chk("bp_stage_valid", 32'(stage_valid), 32'hF);
        chk("bp_stall_cnt", 32'(stall_cnt), 32'd5);
        n_out = 1;
        for (int c = 0; c < 5; c++) begin
            step(0, 0, 1, 0);
            if (s_ov) n_out++;
        end
        chk("bp_drain_count", 32'(n_out), 32'd4);
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        chk("bp_clr", 32'(stall_cnt), 32'd0);

        // Bubble collapse: two items separated by a gap pack against the stalled output
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("bubble_stage_valid", 32'(stage_valid), 32'hC);
        chk("bubble_in_ready", 32'(s_ir), 32'd1);
        chk("bubble_occ", 32'(occupancy), 32'd2);

        // Flush with three items held
        step(0, 1, 0, 0);
        step(1, 1, 1, 0);
        chk("flush_in_ready", 32'(s_ir), 32'd0);
        chk("flush_out_valid", 32'(s_ov), 32'd0);
        step(1, 1, 1, 0);
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_stage_valid", 32'(stage_valid), 32'h0);
        step(0, 0, 1, 0);
        chk("flush_empty", 32'(empty), 32'd1);

        // Stall counter saturation, then clear during an ongoing stall
        for (int c = 0; c < 24; c++) step(0, 1, 0, 0);
        chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
        step(0, 1, 0, 1);
        step(0, 0, 0, 0);
        chk("sat_clr", 32'(stall_cnt), 32'd0);
        step(0, 0, 0, 0);
        chk("sat_reinc", 32'(stall_cnt), 32'd1);

        // Asynchronous reset while full and back-pressured
        @(negedge clk);
        flush = 0; in_valid = 1; out_ready = 0; stall_cnt_clr = 0;
        #2 nreset = 1'b0;
        #1;
        chk("arst_stage_valid", 32'(stage_valid), 32'h0);
        chk("arst_occ", 32'(occupancy), 32'h0);
        chk("arst_stall", 32'(stall_cnt), 32'h0);
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_empty", 32'(empty), 32'h1);
        model_reset();
        @(posedge clk); #2 nreset = 1'b1;
        step(0, 0, 0, 0);
        chk("arst_in_ready", 32'(s_ir), 32'd1);

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            step(logic'($urandom_range(15) == 0), logic'($urandom_range(1)),
                 logic'($urandom_range(9) < 6), logic'($urandom_range(31) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
